// File: rtl/ramspx.sv
// ramspx: single-port RAM with per-byte write enables, selectable write
// behaviour on dout (read-first / write-first / no-change), an optional
// output register stage and an optional zero-fill sequence after reset.
module ramspx #(
    parameter int DW      = 32,
    parameter int AW      = 6,
    parameter int MODE    = 0,
    parameter int OREG    = 0,
    parameter int CLRINIT = 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            req,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    output logic            ready,
    output logic [DW-1:0]   dout,
    output logic            dvalid
);

    localparam int NB     = DW / 8;
    localparam int STAGES = 1 + OREG;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rword;
    logic [DW-1:0] mword;
    logic          acc;

    // vld_pipe[0] is the accept-time strobe, vld_pipe[STAGES] drives dvalid
    logic [STAGES:0] vld_pipe;
    logic [DW-1:0]   dat_pipe [STAGES:1];

    // ready is gated by nreset so it drops at once even when the reset
    // value of the state is RUN (CLRINIT=0)
    assign ready = nreset && (state == RUN);
    assign acc   = req && ready;
    assign rword = mem[addr];

    // per-byte merge of write data over the current word (write-first view)
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign mword[8*i +: 8] = be[i] ? din[8*i +: 8] : rword[8*i +: 8];
    end

    // no-change writes produce no result at all
    assign vld_pipe[0] = acc && !(we && (MODE == 2));

    // CLEAR walks the counter over every address, then hands over to RUN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= (CLRINIT != 0) ? CLEAR : RUN;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == {AW{1'b1}})
                state <= RUN;
        end
    end

    // memory array: zero fill while clearing, byte-enabled writes in RUN;
    // contents are deliberately not touched by reset
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (acc && we) begin
            for (int i = 0; i < NB; i++)
                if (be[i])
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
    end

    // read pipeline: data stages only load with their valid bit, so dout
    // holds between strobes
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe[STAGES:1] <= '0;
            for (int s = 1; s <= STAGES; s++)
                dat_pipe[s] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0])
                dat_pipe[1] <= (we && (MODE == 1)) ? mword : rword;
            for (int s = 2; s <= STAGES; s++)
                if (vld_pipe[s-1])
                    dat_pipe[s] <= dat_pipe[s-1];
        end
    end

    assign dout   = dat_pipe[STAGES];
    assign dvalid = vld_pipe[STAGES];

endmodule

// File: tb/tb_ramspx.sv
// Bench for ramspx: three instances (read-first/OREG0, write-first/OREG1,
// no-change/OREG0) share one stimulus stream; a reference memory produces
// expected words that are queued with their due cycle and checked on the
// falling edge.
module tb_ramspx;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    localparam int OREGS [3] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        nreset;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [2:0]  rdy;
    logic [2:0]  dv;
    logic [31:0] dq [3];

    logic [31:0] mdl [64];
    logic [31:0] last [3];
    exp_t        q [3][$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ramspx #(.MODE(0), .OREG(0)) u0 (.clk(clk), .nreset(nreset), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy[0]), .dout(dq[0]), .dvalid(dv[0]));
    ramspx #(.MODE(1), .OREG(1)) u1 (.clk(clk), .nreset(nreset), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy[1]), .dout(dq[1]), .dvalid(dv[1]));
    ramspx #(.MODE(2), .OREG(0)) u2 (.clk(clk), .nreset(nreset), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(rdy[2]), .dout(dq[2]), .dvalid(dv[2]));

    task automatic chk(input int i, input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut%0d: got %h want %h", tag, i, o, e);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (!nreset) begin
            chk(i, "rst_dout", dq[i], 32'h0);
            chk(i, "rst_dvalid", 32'(dv[i]), 32'h0);
            q[i].delete();
            last[i] = '0;
        end else if (dv[i]) begin
            chk(i, "dvalid_expected", 32'(q[i].size() != 0), 32'h1);
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                chk(i, "dout", dq[i], e.d);
                chk(i, "latency", cyc, e.due);
            end
            last[i] = dq[i];
        end else begin
            chk(i, "hold", dq[i], last[i]);
            if (q[i].size() != 0 && q[i][0].due <= cyc) begin
                chk(i, "dvalid_missing", 32'(dv[i]), 32'h1);
                void'(q[i].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        mon(2);
    end

    task automatic push(input int i, input logic [31:0] d);
        exp_t e;
        e.d   = d;
        e.due = cyc + 1 + OREGS[i];
        q[i].push_back(e);
    endtask

    // one accepted access; called just after a rising edge
    task automatic acc(input logic w, input logic [3:0] b, input logic [5:0] a, input logic [31:0] d);
        logic [31:0] old, mrg;
        req = 1'b1; we = w; be = b; addr = a; din = d;
        old = mdl[a];
        mrg = old;
        for (int k = 0; k < 4; k++)
            if (b[k]) mrg[8*k +: 8] = d[8*k +: 8];
        push(0, old);
        push(1, w ? mrg : old);
        if (!w) push(2, old);
        if (w) mdl[a] = mrg;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // counts falling edges with ready low after reset release
    task automatic wait_clear();
        int n = 0;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        chk(0, "ready_low_cycles", n, 32'd64);
        chk(0, "ready_all", 32'(rdy), 32'h7);
        for (int k = 0; k < 64; k++) mdl[k] = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        nreset = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
        for (int k = 0; k < 3; k++) last[k] = '0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // requests during CLEAR must be ignored (write to addr 7)
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 6'd7; din = 32'hFFFF_FFFF;
        wait_clear();

        // every address reads zero, back to back
        for (int a = 0; a < 64; a++) acc(1'b0, 4'h0, 6'(a), 32'h0);
        idle(3);

        // full write, read-after-write, partial byte write
        acc(1'b1, 4'hF, 6'd5, 32'hDEAD_BEEF);
        acc(1'b0, 4'h0, 6'd5, 32'h0);
        acc(1'b1, 4'b0101, 6'd5, 32'h1122_3344);
        acc(1'b0, 4'h0, 6'd5, 32'h0);
        idle(2);

        // write behaviour on dout
        acc(1'b1, 4'hF, 6'd3, 32'hA);
        idle(2);
        acc(1'b1, 4'hF, 6'd3, 32'hB);
        idle(2);
        acc(1'b0, 4'h0, 6'd3, 32'h0);

        // all-zero byte enables: memory unchanged, still a write
        acc(1'b1, 4'h0, 6'd5, 32'h5555_5555);
        acc(1'b0, 4'h0, 6'd5, 32'h0);
        idle(2);

        // random back-to-back traffic on a small address window
        for (int n = 0; n < 60; n++)
            acc(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom_range(0, 7)), $urandom);
        idle(4);

        // consecutive reads 0,1,2
        acc(1'b0, 4'h0, 6'd0, 32'h0);
        acc(1'b0, 4'h0, 6'd1, 32'h0);
        acc(1'b0, 4'h0, 6'd2, 32'h0);
        idle(4);

        // reset with a read in flight discards it
        acc(1'b1, 4'hF, 6'd9, 32'h1234_5678);
        acc(1'b0, 4'h0, 6'd9, 32'h0);
        nreset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk(i, "async_dout", dq[i], 32'h0);
            chk(i, "async_dvalid", 32'(dv[i]), 32'h0);
        end
        idle(2);
        nreset = 1'b1;

        // reset pulse at clear count 20 restarts the full clear
        repeat (20) @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk(i, "pulse_dout", dq[i], 32'h0);
            chk(i, "pulse_dvalid", 32'(dv[i]), 32'h0);
            chk(i, "pulse_ready", 32'(rdy[i]), 32'h0);
        end
        @(posedge clk); #1 nreset = 1'b1;
        wait_clear();

        // previously written words are zero again
        acc(1'b0, 4'h0, 6'd5, 32'h0);
        acc(1'b0, 4'h0, 6'd9, 32'h0);
        acc(1'b0, 4'h0, 6'd3, 32'h0);
        idle(5);
        for (int i = 0; i < 3; i++)
            chk(i, "queue_drained", 32'(q[i].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
